// File: rtl/clkgen_pkg.sv
// clkgen_pkg: shared types and helpers for the multi-channel clock generator.
// Optional build macro: CLKGEN_ALIGN_EN (see clkgen_multi).
package clkgen_pkg;

    // Request fields are sized for the largest supported configuration
    // (16 channels, 16-bit divide values).
    localparam int CHAN_W_MAX = 4;
    localparam int DIV_W_MAX  = 16;

    // A divide value of zero parks the channel low.
    localparam int DIV_OFF = 0;

    typedef struct packed {
        logic [CHAN_W_MAX-1:0] chan;
        logic [DIV_W_MAX-1:0]  div;
    } cfg_req_t;

    // Channel-select width: clog2(n), but never narrower than one bit.
    function automatic int chan_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clkgen_channel.sv
// clkgen_channel: one divided clock with half-period counter, 50% toggle,
// pre-rise enable strobe and a boundary flag telling the top when a new
// divide value may be loaded without cutting a half-period short.
module clkgen_channel
    import clkgen_pkg::*;
#(
    parameter int DW      = 8,
    parameter int DEF_DIV = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [DW-1:0] load_div,
    input  logic          align,
    output logic          div_clk,
    output logic          clk_en,
    output logic          bnd
);

    logic [DW-1:0] cnt;
    logic [DW-1:0] div;
    logic          run;
    logic          wrap;

    assign run  = (div != DW'(DIV_OFF));
    assign wrap = (cnt == div - DW'(1));

    // Strobe precedes the rising edge; forced low while reset is held so the
    // reset state of the outputs is all-zero.
    assign clk_en = run && wrap && !div_clk && !reset;

    // Safe load point: channel idle, or the edge where div_clk falls.
    assign bnd = !run || (wrap && div_clk);

    // Counter / toggle / divide register; a load always restarts low at cnt 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            div     <= DW'(DEF_DIV);
            cnt     <= '0;
            div_clk <= 1'b0;
        end else if (load) begin
            div     <= load_div;
            cnt     <= '0;
            div_clk <= 1'b0;
        end else if (run) begin
            if (align) begin
                cnt     <= '0;
                div_clk <= 1'b0;
            end else if (wrap) begin
                cnt     <= '0;
                div_clk <= ~div_clk;
            end else begin
                cnt <= cnt + DW'(1);
            end
        end
    end

endmodule

// File: rtl/clkgen_multi.sv
// clkgen_multi: NCH programmable divided clocks with enable strobes.
// A single pending slot holds one accepted update until the target channel
// reaches a safe boundary. Define CLKGEN_ALIGN_EN to make every applied
// update also restart all running channels phase-aligned.
module clkgen_multi
    import clkgen_pkg::*;
#(
    parameter int  NCH     = 4,
    parameter int  DW      = 8,
    parameter int  DEF_DIV = 1,
    localparam int CW      = chan_w(NCH)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           cfg_valid,
    input  logic [CW-1:0]  cfg_chan,
    input  logic [DW-1:0]  cfg_div,
    output logic           cfg_ready,
    output logic           cfg_err,
    output logic [NCH-1:0] div_clk,
    output logic [NCH-1:0] clk_en,
    output logic           busy
);

    cfg_req_t       pend;
    logic           pend_vld;
    logic           err_q;
    logic           accept;
    logic           in_range;
    logic           apply;
    logic [NCH-1:0] bnd;
    logic [NCH-1:0] load;
    logic [NCH-1:0] align;
    logic           unused_div_bits;

    assign busy      = pend_vld;
    assign cfg_ready = !pend_vld;
    assign cfg_err   = err_q;
    assign accept    = cfg_valid && cfg_ready;
    assign in_range  = (32'(cfg_chan) < NCH);
    assign apply     = |load;

    // Divide bits above DW are carried by the request struct but never used.
    assign unused_div_bits = ^pend.div;

`ifdef CLKGEN_ALIGN_EN
    assign align = {NCH{apply}};
`else
    assign align = '0;
`endif

    // Pending slot and error pulse; out-of-range requests are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_vld <= 1'b0;
            pend     <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= accept && !in_range;
            if (accept && in_range) begin
                pend_vld  <= 1'b1;
                pend.chan <= CHAN_W_MAX'(cfg_chan);
                pend.div  <= DIV_W_MAX'(cfg_div);
            end else if (apply) begin
                pend_vld <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign load[i] = pend_vld && (pend.chan == CHAN_W_MAX'(i)) && bnd[i];

        clkgen_channel #(
            .DW      (DW),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .load     (load[i]),
            .load_div (DW'(pend.div)),
            .align    (align[i]),
            .div_clk  (div_clk[i]),
            .clk_en   (clk_en[i]),
            .bnd      (bnd[i])
        );
    end

endmodule

// File: tb/tb_clkgen_multi.sv
// tb_clkgen_multi: directed table plus multi-cycle sequences for clkgen_multi.
// Six channels are used so that channel indices 6 and 7 are out of range.
module tb_clkgen_multi;

    localparam int NCH = 6;
    localparam int DW  = 8;
    localparam int CW  = 3;

    logic           clk;
    logic           reset;
    logic           cfg_valid;
    logic [CW-1:0]  cfg_chan;
    logic [DW-1:0]  cfg_div;
    logic           cfg_ready;
    logic           cfg_err;
    logic [NCH-1:0] div_clk;
    logic [NCH-1:0] clk_en;
    logic           busy;

    int checks;
    int errors;

    clkgen_multi #(.NCH(NCH), .DW(DW), .DEF_DIV(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_chan  (cfg_chan),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .div_clk   (div_clk),
        .clk_en    (clk_en),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic           rst;
        logic           vld;
        logic [CW-1:0]  chan;
        logic [DW-1:0]  div;
        logic [NCH-1:0] e_clk;
        logic [NCH-1:0] e_en;
        logic           e_busy;
        logic           e_rdy;
        logic           e_err;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Advance to the next cycle's sample point (just after the falling edge).
    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    // Present a request and hold it until it is accepted.
    task automatic cfg_write(input int ch, input int dv);
        int n;
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_chan  = CW'(ch);
        cfg_div   = DW'(dv);
        #1;
        n = 0;
        while (!cfg_ready && n < 50) begin
            next_cycle();
            n++;
        end
        if (n >= 50) chk("write_timeout", 1, 0);
        @(posedge clk);
        @(negedge clk);
        cfg_valid = 1'b0;
        #1;
    endtask

    // Wait (bounded) for the pending slot to drain; returns at a sample point.
    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 50) begin
            next_cycle();
            n++;
        end
        if (n >= 50) chk("idle_timeout", 1, 0);
    endtask

    // Channel freshly (re)started low at cnt 0 in the current cycle:
    // expect half cycles low, half high, strobe in the last low cycle.
    task automatic check_from_zero(input int ch, input int half, input int ncyc, input string nm);
        int bad;
        bad = 0;
        for (int i = 0; i < ncyc; i++) begin
            if (i > 0) next_cycle();
            if (div_clk[ch] !== 1'(((i / half) % 2)))         bad++;
            if (clk_en[ch]  !== 1'((i % (2 * half)) == half - 1)) bad++;
        end
        chk(nm, bad, 0);
    endtask

    // Free-running channel of unknown phase: after its first edge the level
    // must flip exactly every half cycles.
    task automatic check_period(input int ch, input int half, input string nm);
        logic s [40];
        int   f;
        int   bad;
        for (int i = 0; i < 40; i++) begin
            next_cycle();
            s[i] = div_clk[ch];
        end
        f = -1;
        for (int i = 1; i < 40; i++)
            if (f < 0 && s[i] != s[i-1]) f = i;
        bad = 0;
        if (f < 0 || f > 2 * half) bad = 1;
        else
            for (int j = f; j < 40; j++)
                if (s[j] != (s[f] ^ 1'(((j - f) / half) % 2))) bad++;
        chk(nm, bad, 0);
    endtask

    vec_t tbl [17];

    initial begin
        int held;
        int bad;
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        cfg_valid = 1'b0;
        cfg_chan  = '0;
        cfg_div   = '0;

        //          rst  vld  ch  div  e_clk  e_en   busy rdy  err
        tbl[0]  = '{1'b1, 1'b0, 3'd0, 8'd0, 6'h00, 6'h00, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 3'd0, 8'd0, 6'h00, 6'h3F, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 3'd0, 8'd0, 6'h3F, 6'h00, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 3'd0, 8'd0, 6'h00, 6'h3F, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 3'd1, 8'd3, 6'h3F, 6'h00, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 3'd0, 8'd0, 6'h00, 6'h3F, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 3'd0, 8'd0, 6'h3F, 6'h00, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 3'd0, 8'd0, 6'h00, 6'h3D, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 3'd0, 8'd0, 6'h3D, 6'h00, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 3'd0, 8'd0, 6'h00, 6'h3F, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 3'd0, 8'd0, 6'h3F, 6'h00, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 3'd0, 8'd0, 6'h02, 6'h3D, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 3'd0, 8'd0, 6'h3F, 6'h00, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 3'd0, 8'd0, 6'h00, 6'h3D, 1'b0, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 3'd0, 8'd0, 6'h3D, 6'h00, 1'b0, 1'b1, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 3'd0, 8'd0, 6'h00, 6'h3F, 1'b0, 1'b1, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 3'd0, 8'd0, 6'h3F, 6'h00, 1'b0, 1'b1, 1'b0};

        repeat (2) @(posedge clk);

        // Reset release, div-by-2 defaults, and chan1 -> div 3 mid-high-phase.
        for (int v = 0; v < 17; v++) begin
            @(negedge clk);
            reset     = tbl[v].rst;
            cfg_valid = tbl[v].vld;
            cfg_chan  = tbl[v].chan;
            cfg_div   = tbl[v].div;
            #1;
            chk($sformatf("v%0d_div_clk", v), int'(div_clk),   int'(tbl[v].e_clk));
            chk($sformatf("v%0d_clk_en", v),  int'(clk_en),    int'(tbl[v].e_en));
            chk($sformatf("v%0d_busy", v),    int'(busy),      int'(tbl[v].e_busy));
            chk($sformatf("v%0d_ready", v),   int'(cfg_ready), int'(tbl[v].e_rdy));
            chk($sformatf("v%0d_err", v),     int'(cfg_err),   int'(tbl[v].e_err));
        end

        // Out-of-range channels: one-cycle error pulse, nothing else moves.
        for (int k = 6; k < 8; k++) begin
            cfg_write(k, 9);
            chk($sformatf("oor%0d_err", k),  int'(cfg_err), 1);
            chk($sformatf("oor%0d_busy", k), int'(busy), 0);
            next_cycle();
            chk($sformatf("oor%0d_err_clr", k), int'(cfg_err), 0);
        end
        check_period(1, 3, "ch1_after_oor");
        check_period(0, 1, "ch0_after_oor");

        // Channel 2 off, then restarted with half-period 5.
        cfg_write(2, 0);
        wait_idle();
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) next_cycle();
            if (div_clk[2] !== 1'b0 || clk_en[2] !== 1'b0) bad++;
        end
        chk("ch2_off_low", bad, 0);
        cfg_write(2, 5);
        wait_idle();
        check_from_zero(2, 5, 30, "ch2_div5");

        // Back-to-back: second request is held off until the first applies.
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_chan  = 3'd3;
        cfg_div   = 8'd2;
        @(posedge clk);
        @(negedge clk);
        cfg_chan = 3'd4;
        cfg_div  = 8'd4;
        #1;
        chk("b2b_held_ready", int'(cfg_ready), 0);
        held = 0;
        while (!cfg_ready && held < 50) begin
            next_cycle();
            held++;
        end
        chk("b2b_held_timeout", int'(held < 50), 1);
        @(posedge clk);
        @(negedge clk);
        cfg_valid = 1'b0;
        #1;
        chk("b2b_second_busy", int'(busy), 1);
        wait_idle();
        check_from_zero(4, 4, 24, "ch4_div4");
        check_period(3, 2, "ch3_div2");

        // Reset while an update is pending drops it and restores defaults.
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_chan  = 3'd1;
        cfg_div   = 8'd7;
        #1;
        held = 0;
        while (!cfg_ready && held < 50) begin
            next_cycle();
            held++;
        end
        @(posedge clk);
        @(negedge clk);
        cfg_valid = 1'b0;
        reset     = 1'b1;
        #1;
        chk("rst_pending_busy", int'(busy), 1);
        chk("rst_hold_clk_en", int'(clk_en), 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(cfg_ready), 1);
        chk("rst_div_clk", int'(div_clk), 0);
        chk("rst_clk_en", int'(clk_en), 6'h3F);
        check_period(1, 1, "ch1_default_after_rst");

        // Channel 0 to half-period 2: everything low in the apply cycle.
        cfg_write(0, 2);
        wait_idle();
        chk("ch0_apply_all_low", int'(div_clk), 0);
        check_from_zero(0, 2, 16, "ch0_div2");

`ifdef CLKGEN_ALIGN_EN
        // Phase alignment: any applied update restarts every running channel.
        cfg_write(1, 3);
        wait_idle();
        cfg_write(0, 1);
        wait_idle();
        chk("align_all_low", int'(div_clk), 0);
        check_from_zero(1, 3, 18, "align_ch1_restart");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
